// File: rtl/row_stack_lock.sv
// Stacker-game row commit: clips the shifter's frozen block against the row
// below, commits it into the stack and relaunches the shifter or ends the game.
module row_stack_lock #(
  parameter int                ROWS       = 8,
  parameter int                WIDTH      = 8,
  parameter logic [WIDTH-1:0]  INIT_BLOCK = 8'b00111000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rowDone,
  input  logic [WIDTH-1:0]       rowBlock,
  input  logic                   newGame,
  output logic                   nextStart,
  output logic [WIDTH-1:0]       nextBlock,
  output logic [2:0]             rowIndex,
  output logic [ROWS*WIDTH-1:0]  stack,
  output logic [6:0]             score,
  output logic [3:0]             trimmed,
  output logic                   gameOver,
  output logic                   gameWin
);

  typedef enum logic [2:0] {
    WAIT_ROW, CHECK, COMMIT, RELAUNCH, LOST, WON
  } stateT;

  stateT stateReg, stateNext;

  logic             rowDonePrevReg;
  logic [WIDTH-1:0] capReg;
  logic [2:0]       rowIndexReg;
  logic [6:0]       scoreReg;
  logic [3:0]       trimmedReg;
  logic [WIDTH-1:0] nextBlockReg;
  logic             nextStartReg;
  logic             gameOverReg;
  logic [WIDTH-1:0] stackRow [ROWS];

  logic             capEn, commitEn, lostEn, relaunchEn, reload;
  logic [WIDTH-1:0] below, overlap;

  function automatic logic [3:0] popCount(input logic [WIDTH-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Row 0 sits on the floor, so anything it lands on is fully supported.
  always_comb begin
    below   = (rowIndexReg == 3'd0) ? '1 : stackRow[rowIndexReg - 3'd1];
    overlap = capReg & below;
  end

  always_ff @(posedge clk) begin
    if (rst) stateReg <= WAIT_ROW;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext  = stateReg;
    capEn      = 1'b0;
    commitEn   = 1'b0;
    lostEn     = 1'b0;
    relaunchEn = 1'b0;
    reload     = 1'b0;
    case (stateReg)
      WAIT_ROW: begin
        if (rowDone && !rowDonePrevReg) begin
          capEn     = 1'b1;
          stateNext = CHECK;
        end
      end
      CHECK:    stateNext = (overlap == '0) ? LOST : COMMIT;
      COMMIT: begin
        commitEn  = 1'b1;
        stateNext = (rowIndexReg == 3'(ROWS - 1)) ? WON : RELAUNCH;
      end
      RELAUNCH: begin
        // Hold start low until the shifter has dropped its stop flag.
        if (!rowDone) begin
          relaunchEn = 1'b1;
          stateNext  = WAIT_ROW;
        end
      end
      LOST: begin
        lostEn = 1'b1;
        if (newGame) begin
          reload    = 1'b1;
          stateNext = WAIT_ROW;
        end
      end
      WON: begin
        if (newGame) begin
          reload    = 1'b1;
          stateNext = WAIT_ROW;
        end
      end
      default:  stateNext = WAIT_ROW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      rowDonePrevReg <= 1'b1;
      capReg         <= '0;
      rowIndexReg    <= '0;
      scoreReg       <= '0;
      trimmedReg     <= '0;
      nextBlockReg   <= INIT_BLOCK;
      nextStartReg   <= 1'b1;
      gameOverReg    <= 1'b0;
    end else begin
      rowDonePrevReg <= rowDone;
      if (capEn) capReg <= rowBlock;
      if (commitEn) begin
        nextBlockReg <= overlap;
        scoreReg     <= scoreReg + {3'b000, popCount(overlap)};
        trimmedReg   <= popCount(capReg) - popCount(overlap);
        nextStartReg <= 1'b0;
        if (rowIndexReg != 3'(ROWS - 1)) rowIndexReg <= rowIndexReg + 3'd1;
      end
      if (relaunchEn) nextStartReg <= 1'b1;
      // Miss outputs are re-applied each LOST cycle; cap is frozen so they hold.
      if (lostEn) begin
        nextStartReg <= 1'b0;
        gameOverReg  <= 1'b1;
        trimmedReg   <= popCount(capReg);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : gRow
      always_ff @(posedge clk) begin
        if (rst || reload)
          stackRow[gi] <= '0;
        else if (commitEn && rowIndexReg == 3'(gi))
          stackRow[gi] <= overlap;
      end
      assign stack[WIDTH*gi +: WIDTH] = stackRow[gi];
    end
  endgenerate

  assign nextStart = nextStartReg;
  assign nextBlock = nextBlockReg;
  assign rowIndex  = rowIndexReg;
  assign score     = scoreReg;
  assign trimmed   = trimmedReg;
  assign gameOver  = gameOverReg;
  assign gameWin   = (stateReg == WON);

endmodule

// File: tb/tb_row_stack_lock.sv
// Bench for row_stack_lock: directed game scenarios plus random games
// compared against a row-by-row model of the stacking rules.
module tb_row_stack_lock;

  logic        clk = 1'b0;
  logic        rst;
  logic        rowDone;
  logic [7:0]  rowBlock;
  logic        newGame;
  logic        nextStart;
  logic [7:0]  nextBlock;
  logic [2:0]  rowIndex;
  logic [63:0] stack;
  logic [6:0]  score;
  logic [3:0]  trimmed;
  logic        gameOver;
  logic        gameWin;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mStack [8];
  int         mIdx, mScore, mTrim;
  logic [7:0] mNext;
  logic       mStart, mOver, mWin;

  row_stack_lock dut (
    .clk(clk), .rst(rst), .rowDone(rowDone), .rowBlock(rowBlock),
    .newGame(newGame), .nextStart(nextStart), .nextBlock(nextBlock),
    .rowIndex(rowIndex), .stack(stack), .score(score), .trimmed(trimmed),
    .gameOver(gameOver), .gameWin(gameWin)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < 8; r++) mStack[r] = 8'h00;
    mIdx = 0; mScore = 0; mTrim = 0; mNext = 8'b00111000;
    mStart = 1'b1; mOver = 1'b0; mWin = 1'b0;
  endtask

  // A stop lands block b on top of the current tower.
  task automatic modelStop(input logic [7:0] b);
    logic [7:0] support, kept;
    support = (mIdx == 0) ? 8'hFF : mStack[mIdx-1];
    kept    = b & support;
    mStart  = 1'b0;
    if (kept == 8'h00) begin
      mOver = 1'b1;
      mTrim = $countones(b);
    end else begin
      mStack[mIdx] = kept;
      mScore += $countones(kept);
      mTrim  = $countones(b) - $countones(kept);
      mNext  = kept;
      if (mIdx == 7) mWin = 1'b1;
      else mIdx++;
    end
  endtask

  task automatic checkAll(input string tag);
    logic [63:0] expStack;
    for (int r = 0; r < 8; r++) expStack[r*8 +: 8] = mStack[r];
    check({tag, ".nextStart"}, 64'(nextStart), 64'(mStart));
    check({tag, ".nextBlock"}, 64'(nextBlock), 64'(mNext));
    check({tag, ".rowIndex"},  64'(rowIndex),  64'(mIdx));
    check({tag, ".stack"},     stack,          expStack);
    check({tag, ".score"},     64'(score),     64'(mScore));
    check({tag, ".trimmed"},   64'(trimmed),   64'(mTrim));
    check({tag, ".gameOver"},  64'(gameOver),  64'(mOver));
    check({tag, ".gameWin"},   64'(gameWin),   64'(mWin));
  endtask

  // Stop the shifter at block b, keep rowDone high for extra cycles, then release.
  task automatic playRow(input logic [7:0] b, input int hold);
    rowBlock = b;
    rowDone  = 1'b1;
    tick();                       // capture edge N
    tick();                       // CHECK at N+1
    tick();                       // results visible after N+2
    modelStop(b);
    $display("row stop block=%b idx=%0d score=%0d trimmed=%0d over=%0b win=%0b",
             b, rowIndex, score, trimmed, gameOver, gameWin);
    checkAll("commit");
    for (int i = 0; i < hold; i++) begin
      tick();
      checkAll("hold");
    end
    rowDone = 1'b0;
    tick();
    if (!mOver && !mWin) mStart = 1'b1;
    checkAll("relaunch");
  endtask

  task automatic pulseNewGame();
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
    modelReset();
    $display("newGame");
    checkAll("newgame");
    tick();
  endtask

  initial begin
    logic [7:0] b;
    int rows;
    rst = 1'b1; rowDone = 1'b1; rowBlock = 8'hFF; newGame = 1'b0;
    modelReset();
    tick(); tick();
    rst = 1'b0;
    checkAll("reset");
    // Stale high rowDone after reset must not be taken as a stop
    repeat (4) tick();
    checkAll("stale");
    rowDone = 1'b0;
    tick();

    // Perfect stack with a long-held stop on row 3
    for (int r = 0; r < 8; r++) playRow(8'b00111000, (r == 3) ? 10 : 0);
    check("perfect.score", 64'(score), 64'd24);
    check("perfect.win",   64'(gameWin), 64'd1);
    check("perfect.row",   64'(rowIndex), 64'd7);
    check("perfect.top",   64'(stack[63:56]), 64'h38);
    pulseNewGame();

    // Trim, then an ignored newGame mid-game, then a miss
    playRow(8'b00111000, 0);
    playRow(8'b00011100, 0);
    check("trim.row1",  64'(stack[15:8]), 64'h18);
    check("trim.next",  64'(nextBlock),   64'h18);
    check("trim.trim",  64'(trimmed),     64'd1);
    check("trim.score", 64'(score),       64'd5);
    newGame = 1'b1; tick(); newGame = 1'b0;
    checkAll("ignoredNewGame");
    playRow(8'b11000000, 0);
    pulseNewGame();

    // Miss on row 1
    playRow(8'b00111000, 0);
    playRow(8'b11000000, 2);
    check("miss.over",  64'(gameOver),    64'd1);
    check("miss.trim",  64'(trimmed),     64'd2);
    check("miss.row1",  64'(stack[15:8]), 64'h00);
    check("miss.start", 64'(nextStart),   64'd0);
    pulseNewGame();

    // rst together with a rising rowDone mid-game: no capture afterwards
    playRow(8'b00111000, 0);
    playRow(8'b01111000, 0);
    rowBlock = 8'b00110000;
    rowDone  = 1'b1;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    checkAll("midRst");
    repeat (4) tick();
    checkAll("midRstHeld");
    rowDone = 1'b0;
    tick();

    // Random games
    for (int g = 0; g < 12; g++) begin
      rows = 0;
      while (!mOver && !mWin && rows < 8) begin
        case ($urandom_range(0, 9))
          0:       b = 8'h00;
          1, 2:    b = 8'($urandom);
          default: b = $urandom_range(0, 1) ? (mNext << $urandom_range(0, 1))
                                            : (mNext >> $urandom_range(0, 1));
        endcase
        playRow(b, $urandom_range(0, 3));
        rows++;
      end
      check("random.end", 64'(gameOver | gameWin), 64'd1);
      pulseNewGame();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
